// File: rtl/veggie_comm_pkg.sv
// Shared FPGA<->Arduino serial link definitions: frame width, transmitter states, checksum.
// Also used by arduino_fpga_comm so both ends agree on the frame layout.
package veggie_comm_pkg;

  localparam int FRAME_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_ACK,
    GAP
  } tx_state_e;

  // Checksum nibble: XOR of the command and the four payload nibbles.
  function automatic logic [3:0] frame_chk(input logic [3:0] cmd, input logic [15:0] data);
    return cmd ^ data[15:12] ^ data[11:8] ^ data[7:4] ^ data[3:0];
  endfunction

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Half-period divider: one-cycle tick every DIV enabled cycles; clr restarts the count at 0.
// Latency: first tick DIV cycles after clr; no backpressure.
module bit_tick_gen #(
  parameter int DIV = 250,
  parameter int W   = 9
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_end;

  assign at_end = (cnt_q == W'(DIV - 1));
  assign tick_o = en_i && !clr_i && at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fpga_arduino_tx.sv
// Sends 24-bit {cmd, data, chk} frames MSB first to the Arduino and waits for an acknowledge, resending on timeout.
// Frame starts the cycle after tx_valid&tx_ready; tx_ready is low from acceptance until tx_done/tx_err.
module fpga_arduino_tx
  import veggie_comm_pkg::*;
#(
  parameter int CLK_DIV     = 250,
  parameter int ACK_TIMEOUT = 50000,
  parameter int MAX_RETRY   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_valid,
  input  logic [3:0]  tx_cmd,
  input  logic [15:0] tx_data,
  output logic        tx_ready,
  output logic        ser_clk,
  output logic        ser_data,
  output logic        ser_frame,
  input  logic        ser_ack,
  output logic        tx_done,
  output logic        tx_err,
  output logic        busy
);

  localparam int CNT_W   = cnt_width(2 * CLK_DIV, ACK_TIMEOUT);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_W - 1);

  tx_state_e            state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     wait_q, wait_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 ser_clk_q, ser_clk_d;
  logic                 ser_frame_q, ser_frame_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_err_q, tx_err_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 ack_meta_q, ack_sync_q, ack_prev_q;

  logic                 ack_rise;
  logic                 half_tick;
  logic                 tick_clr;
  logic                 start_frame;
  logic [FRAME_W-1:0]   start_src;
  logic [FRAME_W-1:0]   new_frame;

  assign new_frame = {tx_cmd, tx_data, frame_chk(tx_cmd, tx_data)};
  assign ack_rise  = ack_sync_q && !ack_prev_q;

  bit_tick_gen #(
    .DIV (CLK_DIV),
    .W   (CNT_W)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (state_q == SHIFT),
    .clr_i   (tick_clr),
    .tick_o  (half_tick)
  );

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    wait_d      = wait_q;
    retry_d     = retry_q;
    ser_clk_d   = ser_clk_q;
    ser_frame_d = ser_frame_q;
    tx_done_d   = 1'b0;
    tx_err_d    = 1'b0;
    tick_clr    = 1'b0;
    start_frame = 1'b0;
    start_src   = '0;

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          frame_d     = new_frame;
          retry_d     = '0;
          start_frame = 1'b1;
          start_src   = new_frame;
        end
      end
      SHIFT: begin
        if (half_tick) begin
          if (!ser_clk_q) begin
            ser_clk_d = 1'b1;
          end else if (bit_cnt_q == LAST_BIT) begin
            ser_clk_d   = 1'b0;
            ser_frame_d = 1'b0;
            shift_d     = '0;
            wait_d      = '0;
            state_d     = WAIT_ACK;
          end else begin
            // Data only moves on the falling ser_clk edge; the Arduino samples on the rising one.
            ser_clk_d = 1'b0;
            shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      WAIT_ACK: begin
        if (ack_rise) begin
          tx_done_d = 1'b1;
          state_d   = IDLE;
        end else if (wait_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            wait_d  = '0;
            state_d = GAP;
          end else begin
            tx_err_d = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      GAP: begin
        if (wait_q == CNT_W'(2 * CLK_DIV - 1)) begin
          start_frame = 1'b1;
          start_src   = frame_q;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      shift_d     = start_src;
      bit_cnt_d   = '0;
      ser_clk_d   = 1'b0;
      ser_frame_d = 1'b1;
      tick_clr    = 1'b1;
      state_d     = SHIFT;
    end

    tx_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      wait_q      <= '0;
      retry_q     <= '0;
      ser_clk_q   <= 1'b0;
      ser_frame_q <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;
      tx_ready_q  <= 1'b0;
      ack_meta_q  <= 1'b0;
      ack_sync_q  <= 1'b0;
      ack_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      wait_q      <= wait_d;
      retry_q     <= retry_d;
      ser_clk_q   <= ser_clk_d;
      ser_frame_q <= ser_frame_d;
      tx_done_q   <= tx_done_d;
      tx_err_q    <= tx_err_d;
      tx_ready_q  <= tx_ready_d;
      ack_meta_q  <= ser_ack;
      ack_sync_q  <= ack_meta_q;
      ack_prev_q  <= ack_sync_q;
    end
  end

  // Shift register is cleared outside a frame, so its MSB is the line value directly.
  assign ser_data  = shift_q[FRAME_W-1];
  assign ser_clk   = ser_clk_q;
  assign ser_frame = ser_frame_q;
  assign tx_done   = tx_done_q;
  assign tx_err    = tx_err_q;
  assign tx_ready  = tx_ready_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fpga_arduino_tx.sv
// Directed bench for fpga_arduino_tx with CLK_DIV=4, ACK_TIMEOUT=100, MAX_RETRY=2.
module tb_fpga_arduino_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tx_valid = 1'b0;
  logic [3:0]  tx_cmd = '0;
  logic [15:0] tx_data = '0;
  logic        ser_ack = 1'b0;
  logic        tx_ready, ser_clk, ser_data, ser_frame, tx_done, tx_err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  fpga_arduino_tx #(
    .CLK_DIV     (4),
    .ACK_TIMEOUT (100),
    .MAX_RETRY   (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tx_valid  (tx_valid),
    .tx_cmd    (tx_cmd),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .ser_clk   (ser_clk),
    .ser_data  (ser_data),
    .ser_frame (ser_frame),
    .ser_ack   (ser_ack),
    .tx_done   (tx_done),
    .tx_err    (tx_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Line monitor: collects bits on ser_clk rises, frame/gap lengths and pulse counts.
  int          frame_cyc = 0, low_run = 0, gap_last = 0, gap_prev = 0;
  int          frames_n = 0, bits_n = 0, done_n = 0, err_n = 0;
  logic [23:0] rx_bits = '0;
  logic        frame_prev = 1'b0, sclk_prev = 1'b0;

  always @(negedge clk) begin
    if (ser_frame) frame_cyc <= frame_cyc + 1;
    else           low_run   <= low_run + 1;
    if (ser_frame && !frame_prev) begin
      frames_n <= frames_n + 1;
      gap_prev <= gap_last;
      gap_last <= low_run;
      low_run  <= 0;
    end
    frame_prev <= ser_frame;
    if (ser_clk && !sclk_prev) begin
      rx_bits <= {rx_bits[22:0], ser_data};
      bits_n  <= bits_n + 1;
    end
    sclk_prev <= ser_clk;
    if (tx_done) done_n <= done_n + 1;
    if (tx_err)  err_n  <= err_n + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame_end(output int k);
    k = 0;
    while (ser_frame === 1'b1 && k < 400) begin
      step();
      k++;
    end
  endtask

  task automatic wait_done(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (tx_done !== 1'b1 && k < 12);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, fc0, bn0, fr0, dn0, en0;

    // Reset state
    repeat (3) step();
    chk("rst_outputs", {tx_ready, busy, ser_clk, ser_data, ser_frame, tx_done, tx_err}, 7'b0);
    reset_n = 1'b1;
    step();
    chk("rdy_after_rst", tx_ready, 1'b1);

    // A: basic frame 0x3/0xA5C1, ack 10 cycles after frame end
    tx_cmd = 4'h3; tx_data = 16'hA5C1; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0; tx_cmd = 4'hF; tx_data = 16'h0000;
    chk("a_start", {tx_ready, busy, ser_frame, ser_clk, ser_data}, 5'b01100);
    fc0 = frame_cyc; bn0 = bits_n; dn0 = done_n; en0 = err_n;
    wait_frame_end(k);
    chk("a_frame_len", k, 192);
    chk("a_frame_cyc", frame_cyc - fc0, 192);
    chk("a_bit_count", bits_n - bn0, 24);
    chk("a_bits", rx_bits, 24'h3A5C11);
    chk("a_line_idle", {busy, ser_clk, ser_data}, 3'b100);
    repeat (9) step();
    ser_ack = 1'b1;
    wait_done(k);
    chk("a_done_lat", k, 3);
    chk("a_no_err", tx_err, 1'b0);
    step();
    ser_ack = 1'b0;
    chk("a_after_done", {tx_done, tx_ready, busy}, 3'b010);
    chk("a_done_cnt", {done_n - dn0, err_n - en0}, {32'd1, 32'd0});

    // B: no acknowledge -> three attempts then tx_err
    tx_cmd = 4'h5; tx_data = 16'h1234; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    fc0 = frame_cyc; fr0 = frames_n; dn0 = done_n; en0 = err_n;
    k = 0;
    while (tx_err !== 1'b1 && k < 2000) begin
      step();
      k++;
    end
    chk("b_err_lat", k, 892);
    chk("b_err_no_done", tx_done, 1'b0);
    step();
    chk("b_after_err", {tx_err, tx_ready, busy}, 3'b010);
    chk("b_frames", frames_n - fr0, 3);
    chk("b_frame_cyc", frame_cyc - fc0, 576);
    chk("b_gap1", gap_prev, 108);
    chk("b_gap2", gap_last, 108);
    chk("b_pulses", {done_n - dn0, err_n - en0}, {32'd0, 32'd1});
    chk("b_bits", rx_bits, 24'h512341);

    // C: ack during SHIFT is ignored, retry follows, then acknowledged
    tx_cmd = 4'hC; tx_data = 16'h00FF; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    fr0 = frames_n; dn0 = done_n; en0 = err_n;
    repeat (20) step();
    ser_ack = 1'b1;
    repeat (5) step();
    ser_ack = 1'b0;
    k = 0;
    while (frames_n - fr0 < 2 && k < 600) begin
      step();
      k++;
    end
    chk("c_retry_sent", frames_n - fr0, 2);
    chk("c_no_done", done_n - dn0, 0);
    wait_frame_end(k);
    ser_ack = 1'b1;
    wait_done(k);
    chk("c_done", tx_done, 1'b1);
    step();
    ser_ack = 1'b0;
    chk("c_bits", rx_bits, 24'hC00FFC);
    chk("c_pulses", {done_n - dn0, err_n - en0}, {32'd1, 32'd0});

    // D: ack edge lands on the timeout cycle -> ack wins
    tx_cmd = 4'h7; tx_data = 16'h0001; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    fr0 = frames_n; dn0 = done_n; en0 = err_n;
    wait_frame_end(k);
    repeat (97) step();
    ser_ack = 1'b1;
    wait_done(k);
    chk("d_done_lat", k, 3);
    chk("d_no_err", tx_err, 1'b0);
    step();
    ser_ack = 1'b0;
    repeat (20) step();
    chk("d_idle", {busy, tx_ready, ser_frame}, 3'b010);
    chk("d_frames", frames_n - fr0, 1);
    chk("d_bits", rx_bits, 24'h700016);
    chk("d_pulses", {done_n - dn0, err_n - en0}, {32'd1, 32'd0});

    // E: reset at bit 10 aborts immediately
    tx_cmd = 4'h2; tx_data = 16'h1111; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    bn0 = bits_n; dn0 = done_n; en0 = err_n;
    k = 0;
    while (bits_n - bn0 < 10 && k < 200) begin
      step();
      k++;
    end
    chk("e_reached_bit10", bits_n - bn0, 10);
    #1;
    reset_n = 1'b0;
    #1;
    chk("e_async_clear", {tx_ready, busy, ser_clk, ser_data, ser_frame, tx_done, tx_err}, 7'b0);
    repeat (3) step();
    chk("e_held_clear", {tx_ready, busy, ser_clk, ser_data, ser_frame, tx_done, tx_err}, 7'b0);
    reset_n = 1'b1;
    step();
    chk("e_rdy_release", {tx_ready, busy}, 2'b10);
    step();
    chk("e_no_pulses", {done_n - dn0, err_n - en0}, {32'd0, 32'd0});

    // F: tx_valid held high, inputs changed mid-frame, back-to-back packets
    dn0 = done_n;
    tx_cmd = 4'h1; tx_data = 16'h0F0F; tx_valid = 1'b1;
    step();
    tx_cmd = 4'hE; tx_data = 16'hBEEF;
    wait_frame_end(k);
    chk("f_bits1", rx_bits, 24'h10F0F1);
    ser_ack = 1'b1;
    wait_done(k);
    chk("f_done1", tx_done, 1'b1);
    ser_ack = 1'b0;
    step();
    chk("f_b2b_accept", {busy, ser_frame, tx_ready}, 3'b110);
    tx_cmd = 4'h3; tx_data = 16'h0000;
    wait_frame_end(k);
    chk("f_bits2", rx_bits, 24'hEBEEFA);
    ser_ack = 1'b1;
    wait_done(k);
    chk("f_done2", tx_done, 1'b1);
    tx_valid = 1'b0;
    ser_ack = 1'b0;
    step();
    chk("f_idle", {busy, tx_ready}, 2'b01);
    chk("f_done_cnt", done_n - dn0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
